// File: rtl/quadrature_step_decoder_pkg.sv
// Shared encodings for the quadrature step decoder: resolution modes, Gray
// state constants and transition classification helpers.
package quad_dec_pkg;

  typedef enum logic [1:0] {
    MODE_X4   = 2'b00,
    MODE_X2   = 2'b01,
    MODE_X1   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    TR_NONE    = 2'b00,
    TR_UP      = 2'b01,
    TR_DOWN    = 2'b10,
    TR_ILLEGAL = 2'b11
  } trans_e;

  // Forward rotation visits {A,B} = S0 -> S1 -> S2 -> S3 -> S0.
  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b01;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b10;

  localparam int FILT_CNT_W = 4;
  localparam int ERR_CNT_W  = 8;

  function automatic logic [1:0] gray_pos(input logic [1:0] s);
    case (s)
      GRAY_S0: return 2'd0;
      GRAY_S1: return 2'd1;
      GRAY_S2: return 2'd2;
      GRAY_S3: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic trans_e classify(input logic [1:0] prev_s, input logic [1:0] cur_s);
    logic [1:0] delta_s;
    delta_s = gray_pos(cur_s) - gray_pos(prev_s);
    case (delta_s)
      2'd0:    return TR_NONE;
      2'd1:    return TR_UP;
      2'd2:    return TR_ILLEGAL;
      2'd3:    return TR_DOWN;
      default: return TR_NONE;
    endcase
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc8(input logic [ERR_CNT_W-1:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/quadrature_step_decoder_if.sv
// Encoder/control bundle between a host (master) and the decoder (slave).
interface quadrature_step_decoder_if #(
  parameter int WIDTH = 8
);
  logic             enc_a;
  logic             enc_b;
  logic             enc_idx;
  logic [1:0]       mode;
  logic             idx_load_en;
  logic [WIDTH-1:0] idx_val;
  logic             err_clr;
  logic             cnt_enable;
  logic             cnt_up_down;
  logic             cnt_load_en;
  logic [WIDTH-1:0] cnt_load_val;
  logic             ready;
  logic             phase_err;
  logic [7:0]       err_cnt;

  modport master (
    output enc_a, enc_b, enc_idx, mode, idx_load_en, idx_val, err_clr,
    input  cnt_enable, cnt_up_down, cnt_load_en, cnt_load_val, ready, phase_err, err_cnt
  );

  modport slave (
    input  enc_a, enc_b, enc_idx, mode, idx_load_en, idx_val, err_clr,
    output cnt_enable, cnt_up_down, cnt_load_en, cnt_load_val, ready, phase_err, err_cnt
  );
endinterface

// File: rtl/quadrature_step_decoder_input_sync_filter.sv
// Metastability synchronizer followed by a hold-time filter for one raw
// encoder line; while prime is high the filter follows the synchronizer.
module input_sync_filter
  import quad_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic prime,
  output logic level
);

  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [FILT_CNT_W-1:0]  cnt_r;
  logic                   level_r;
  logic                   sync_s;

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign level  = level_r;

  // Shift the raw level through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
    end
  end

  // Accept a new level only after it has differed for FILTER_LEN straight cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {FILT_CNT_W{1'b0}};
      level_r <= 1'b0;
    end else if (prime) begin
      cnt_r   <= {FILT_CNT_W{1'b0}};
      level_r <= sync_s;
    end else if (sync_s == level_r) begin
      cnt_r   <= {FILT_CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= {FILT_CNT_W{1'b0}};
      level_r <= sync_s;
    end else begin
      cnt_r   <= cnt_r + 4'd1;
    end
  end

endmodule

// File: rtl/quadrature_step_decoder.sv
// Quadrature decoder: filters A/B/index, converts Gray transitions into
// single-cycle step/load commands for an external up/down counter.
module quadrature_step_decoder
  import quad_dec_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int FILTER_LEN  = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                      clk,
  input logic                      rst_n,
  quadrature_step_decoder_if.slave bus
);

  localparam int         PRIME_LEN  = SYNC_STAGES + FILTER_LEN + 1;
  localparam logic [4:0] PRIME_DONE = 5'(PRIME_LEN);

  logic [4:0]       prime_cnt_r;
  logic             ready_r;
  logic             priming_s;
  logic             filt_a_s;
  logic             filt_b_s;
  logic             filt_idx_s;
  logic [1:0]       cur_ab_r;
  logic [1:0]       prev_ab_r;
  logic             idx_cur_r;
  logic             idx_prev_r;
  trans_e           tr_s;
  logic             legal_s;
  logic             step_s;
  logic             dir_s;
  logic             err_s;
  logic             load_s;
  logic             cnt_enable_r;
  logic             cnt_load_en_r;
  logic             cnt_up_down_r;
  logic [WIDTH-1:0] cnt_load_val_r;
  logic             phase_err_r;
  logic [7:0]       err_cnt_r;

  assign priming_s = (prime_cnt_r != PRIME_DONE);

  input_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .raw(bus.enc_a), .prime(priming_s), .level(filt_a_s)
  );
  input_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .raw(bus.enc_b), .prime(priming_s), .level(filt_b_s)
  );
  input_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_idx (
    .clk(clk), .rst_n(rst_n), .raw(bus.enc_idx), .prime(priming_s), .level(filt_idx_s)
  );

  // Count out the prime window after reset release, then raise ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_cnt_r <= 5'd0;
      ready_r     <= 1'b0;
    end else if (priming_s) begin
      prime_cnt_r <= prime_cnt_r + 5'd1;
      ready_r     <= (prime_cnt_r == (PRIME_DONE - 5'd1));
    end else begin
      prime_cnt_r <= prime_cnt_r;
      ready_r     <= 1'b1;
    end
  end

  // Snapshot filtered levels; while priming both snapshots track so no edge is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ab_r   <= 2'b00;
      prev_ab_r  <= 2'b00;
      idx_cur_r  <= 1'b0;
      idx_prev_r <= 1'b0;
    end else if (priming_s) begin
      cur_ab_r   <= {filt_a_s, filt_b_s};
      prev_ab_r  <= {filt_a_s, filt_b_s};
      idx_cur_r  <= filt_idx_s;
      idx_prev_r <= filt_idx_s;
    end else begin
      cur_ab_r   <= {filt_a_s, filt_b_s};
      prev_ab_r  <= cur_ab_r;
      idx_cur_r  <= filt_idx_s;
      idx_prev_r <= idx_cur_r;
    end
  end

  // Decode the snapshot pair into step, direction, error and load requests.
  always_comb begin
    tr_s    = classify(prev_ab_r, cur_ab_r);
    legal_s = (tr_s == TR_UP) || (tr_s == TR_DOWN);
    dir_s   = (tr_s == TR_UP);
    step_s  = 1'b0;
    if (priming_s) begin
      step_s = 1'b0;
    end else begin
      case (mode_e'(bus.mode))
        MODE_X2: step_s = legal_s && (prev_ab_r[1] != cur_ab_r[1]);
        MODE_X1: begin
          step_s = legal_s && !prev_ab_r[1] && cur_ab_r[1];
          dir_s  = cur_ab_r[0];
        end
        default: step_s = legal_s;
      endcase
    end
    err_s  = !priming_s && (tr_s == TR_ILLEGAL);
    load_s = !priming_s && !idx_prev_r && idx_cur_r && bus.idx_load_en;
  end

  // Registered counter commands and error bookkeeping; a load replaces a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_enable_r   <= 1'b0;
      cnt_load_en_r  <= 1'b0;
      cnt_up_down_r  <= 1'b1;
      cnt_load_val_r <= {WIDTH{1'b0}};
      phase_err_r    <= 1'b0;
      err_cnt_r      <= 8'd0;
    end else begin
      cnt_enable_r  <= step_s | load_s;
      cnt_load_en_r <= load_s;
      if (load_s) begin
        cnt_load_val_r <= bus.idx_val;
      end
      if (step_s) begin
        cnt_up_down_r <= dir_s;
      end
      if (err_s) begin
        phase_err_r <= 1'b1;
        err_cnt_r   <= bus.err_clr ? 8'd1 : sat_inc8(err_cnt_r);
      end else if (bus.err_clr) begin
        phase_err_r <= 1'b0;
        err_cnt_r   <= 8'd0;
      end
    end
  end

  assign bus.cnt_enable   = cnt_enable_r;
  assign bus.cnt_load_en  = cnt_load_en_r;
  assign bus.cnt_up_down  = cnt_up_down_r;
  assign bus.cnt_load_val = cnt_load_val_r;
  assign bus.ready        = ready_r;
  assign bus.phase_err    = phase_err_r;
  assign bus.err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Randomized bench: segment-level encoder model predicts every output cycle by cycle.
module tb_quadrature_step_decoder;

  localparam int N       = 16384;
  localparam int EV_LAT  = 8;   // drive point to visible output: 2 sync + 4 filter + 2
  localparam int RDY_LAT = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  quadrature_step_decoder_if #(.WIDTH(8)) bus_if();

  quadrature_step_decoder #(.WIDTH(8), .FILTER_LEN(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit         ev_step [N];
  bit         ev_dir  [N];
  bit         ev_load [N];
  bit         ev_err  [N];
  bit         ev_clr  [N];
  logic [7:0] ev_lval [N];

  logic       m_ud;
  logic       m_pe;
  int         m_ec;
  logic [7:0] m_lv;
  int         ready_at;
  logic [1:0] m_ab;
  logic       m_idx;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int gpos(input logic [1:0] s);
    logic [1:0] up_seq [4];
    up_seq = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) if (up_seq[i] == s) return i;
    return 0;
  endfunction

  int  mk;
  bit  en_e, ld_e;
  // Apply scheduled events for this cycle, then compare every output.
  always @(negedge clk) begin
    mk = cyc; en_e = 1'b0; ld_e = 1'b0;
    if (mk < N) begin
      if (ev_err[mk]) begin
        m_pe = 1'b1;
        m_ec = ev_clr[mk] ? 1 : ((m_ec < 255) ? m_ec + 1 : 255);
      end else if (ev_clr[mk]) begin
        m_pe = 1'b0;
        m_ec = 0;
      end
      if (ev_step[mk]) m_ud = ev_dir[mk];
      if (ev_load[mk]) m_lv = ev_lval[mk];
      en_e = ev_step[mk] | ev_load[mk];
      ld_e = ev_load[mk];
    end
    chk_eq("cnt_enable",   bus_if.cnt_enable,   en_e);
    chk_eq("cnt_load_en",  bus_if.cnt_load_en,  ld_e);
    chk_eq("cnt_up_down",  bus_if.cnt_up_down,  m_ud);
    chk_eq("cnt_load_val", bus_if.cnt_load_val, m_lv);
    chk_eq("phase_err",    bus_if.phase_err,    m_pe);
    chk_eq("err_cnt",      bus_if.err_cnt,      m_ec);
    chk_eq("ready",        bus_if.ready,        (mk >= ready_at));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    for (int k = cyc + 1; k < N; k++) begin
      ev_step[k] = 1'b0; ev_dir[k] = 1'b0; ev_load[k] = 1'b0;
      ev_err[k]  = 1'b0; ev_clr[k] = 1'b0; ev_lval[k] = 8'h00;
    end
    m_ud = 1'b1; m_pe = 1'b0; m_ec = 0; m_lv = 8'h00;
    ready_at = 2 * N;
    bus_if.err_clr = 1'b0;
    repeat (hold) tick();
    rst_n    = 1'b1;
    ready_at = cyc + RDY_LAT;
    m_ab     = {bus_if.enc_a, bus_if.enc_b};
    m_idx    = bus_if.enc_idx;
    repeat (10) tick();
  endtask

  // Move the encoder to a new {A,B} and index level and hold it.
  task automatic seg(input logic [1:0] ab, input logic idx, input int hold, input int clr_off);
    int   n, d;
    bit   stp, dir, err, ld;
    n = cyc; stp = 1'b0; dir = 1'b0; err = 1'b0;
    if (ab != m_ab) begin
      d = (gpos(ab) - gpos(m_ab) + 4) % 4;
      if (d == 2) begin
        err = 1'b1;
      end else begin
        dir = (d == 1);
        case (bus_if.mode)
          2'b01:   stp = (ab[1] != m_ab[1]);
          2'b10: begin
            stp = !m_ab[1] && ab[1];
            dir = ab[0];
          end
          default: stp = 1'b1;
        endcase
      end
    end
    ld = !m_idx && idx && bus_if.idx_load_en;
    if (n + EV_LAT < N) begin
      ev_step[n+EV_LAT] = stp;
      ev_dir[n+EV_LAT]  = dir;
      ev_err[n+EV_LAT]  = err;
      ev_load[n+EV_LAT] = ld;
      ev_lval[n+EV_LAT] = bus_if.idx_val;
    end
    m_ab = ab; m_idx = idx;
    bus_if.enc_a = ab[1]; bus_if.enc_b = ab[0]; bus_if.enc_idx = idx;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (clr_off != 0 && cyc + 1 == n + clr_off && cyc + 1 < N) begin
        bus_if.err_clr = 1'b1;
        ev_clr[cyc+1]  = 1'b1;
      end else begin
        bus_if.err_clr = 1'b0;
      end
    end
  endtask

  task automatic pulse_clr();
    bus_if.err_clr = 1'b1;
    if (cyc + 1 < N) ev_clr[cyc+1] = 1'b1;
    tick();
    bus_if.err_clr = 1'b0;
    repeat (2) tick();
  endtask

  task automatic glitch(input int g);
    bus_if.enc_a = ~m_ab[1];
    repeat (g) tick();
    bus_if.enc_a = m_ab[1];
    repeat (6) tick();
  endtask

  initial begin
    int hold, coff;
    bus_if.enc_a = 1'b0; bus_if.enc_b = 1'b0; bus_if.enc_idx = 1'b0;
    bus_if.mode = 2'b00; bus_if.idx_load_en = 1'b0; bus_if.idx_val = 8'h00;
    bus_if.err_clr = 1'b0;
    do_reset(3);

    // x4 forward rotation, then rejected glitches
    seg(2'b01, 1'b0, 10, 0); seg(2'b11, 1'b0, 10, 0);
    seg(2'b10, 1'b0, 10, 0); seg(2'b00, 1'b0, 10, 0);
    glitch(3); glitch(1);

    // x1 then x2 reverse rotation, two turns each
    bus_if.mode = 2'b10;
    repeat (2) begin
      seg(2'b10, 1'b0, 10, 0); seg(2'b11, 1'b0, 10, 0);
      seg(2'b01, 1'b0, 10, 0); seg(2'b00, 1'b0, 10, 0);
    end
    bus_if.mode = 2'b01;
    repeat (2) begin
      seg(2'b10, 1'b0, 10, 0); seg(2'b11, 1'b0, 10, 0);
      seg(2'b01, 1'b0, 10, 0); seg(2'b00, 1'b0, 10, 0);
    end

    // 300 double-phase jumps saturate the error counter
    bus_if.mode = 2'b00;
    repeat (150) begin
      seg(2'b11, 1'b0, 8, 0); seg(2'b00, 1'b0, 8, 0);
    end
    pulse_clr();
    seg(2'b11, 1'b0, 10, 8);
    seg(2'b00, 1'b0, 10, 0);
    pulse_clr();

    // index load landing on an up step
    bus_if.idx_load_en = 1'b1; bus_if.idx_val = 8'hA5;
    seg(2'b01, 1'b1, 10, 0);
    seg(2'b01, 1'b0, 10, 0);
    bus_if.idx_load_en = 1'b0;

    repeat (300) begin
      bus_if.mode        = 2'($urandom_range(0, 3));
      bus_if.idx_load_en = 1'($urandom_range(0, 1));
      bus_if.idx_val     = 8'($urandom);
      hold = $urandom_range(8, 12);
      coff = ($urandom_range(0, 9) == 0) ? $urandom_range(1, hold) : 0;
      seg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), hold, coff);
      if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, 3));
    end

    // reset in the middle of a filter count, inputs settle at 11
    bus_if.mode = 2'b00;
    seg(2'b00, 1'b0, 10, 0);
    bus_if.enc_a = 1'b1; bus_if.enc_b = 1'b1;
    repeat (3) tick();
    do_reset(2);
    seg(2'b10, 1'b0, 10, 0);
    seg(2'b00, 1'b0, 10, 0);

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quadrature_step_decoder.md
QUADRATURE_STEP_DECODER -- requirements
Module: quadrature_step_decoder

Interface
REQ-001 Parameter WIDTH, default 8, width of the load value.
REQ-002 Parameter FILTER_LEN, default 4, cycles an input must hold a new level before it is accepted; legal range 1..15.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer flops per encoder input; legal range 2..3.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 enc_a, enc_b, enc_idx  input  1 each  raw asynchronous encoder phases and index.
REQ-007 mode  input  2  decode resolution: 00 x4, 01 x2, 10 x1, 11 treated as x4.
REQ-008 idx_load_en  input  1  arms counter preload on index.
REQ-009 idx_val  input  WIDTH  value loaded on index.
REQ-010 err_clr  input  1  clears phase_err and err_cnt.
REQ-011 cnt_enable, cnt_up_down, cnt_load_en  output  1 each  drive a loadable up/down counter (enable, 1 = up, load).
REQ-012 cnt_load_val  output  WIDTH  preload value for the counter.
REQ-013 ready  output  1  decoder primed; steps valid.
REQ-014 phase_err  output  1  sticky illegal-transition flag.
REQ-015 err_cnt  output  8  saturating illegal-transition count.

Function
REQ-016 Each encoder input SHALL pass through SYNC_STAGES flops, then a filter whose output changes only after the synchronized level has differed from it for FILTER_LEN consecutive cycles; any return to the old level restarts the count.
REQ-017 Filtered state S = {A,B}; the up sequence SHALL be 00->01->11->10->00 and the down sequence its reverse.
REQ-018 x4: every legal S change SHALL produce one step; x2: only changes where A toggles; x1: only A rising, direction up if B=1, down if B=0.
REQ-019 A step SHALL assert cnt_enable for exactly one cycle, with cnt_up_down valid that cycle; latency from the first clk edge sampling a stable new raw level to cnt_enable SHALL be SYNC_STAGES+FILTER_LEN+1 cycles.
REQ-020 cnt_up_down SHALL be registered and hold the last step direction between steps.
REQ-021 A change of both A and B in one cycle SHALL produce no step, set phase_err, and increment err_cnt, saturating at 255.
REQ-022 err_clr SHALL clear phase_err and err_cnt next cycle; a simultaneous new error SHALL win (phase_err=1, err_cnt=1).
REQ-023 A filtered enc_idx rising edge with idx_load_en=1 SHALL assert cnt_load_en and cnt_enable for one cycle, with cnt_load_val = idx_val sampled that cycle.
REQ-024 Index load coinciding with a step: load SHALL win, the step SHALL be dropped, and cnt_up_down SHALL still update.
REQ-025 cnt_load_val SHALL hold its last loaded value between loads.
REQ-026 Prime phase: for SYNC_STAGES+FILTER_LEN+1 cycles after reset release, filters SHALL track synchronized inputs directly, no steps, loads or errors SHALL be generated, and ready=0; ready SHALL be 1 from the following cycle until reset.
REQ-027 Changes to mode SHALL take effect on the next decoded transition.

Reset
REQ-028 rst_n low SHALL asynchronously force cnt_enable=0, cnt_load_en=0, cnt_up_down=1, cnt_load_val=0, ready=0, phase_err=0, err_cnt=0, and zero all synchronizer, filter and prime state.
REQ-029 Reset asserted mid-operation SHALL discard any in-progress filter count; no step SHALL be emitted from pre-reset input history.

Structure
REQ-030 Package quad_dec_pkg SHALL hold the mode encodings (MODE_X4, MODE_X2, MODE_X1) and the Gray state constants.
REQ-031 Sub-module input_sync_filter (synchronizer plus filter, parameters SYNC_STAGES and FILTER_LEN) SHALL be instantiated once each for A, B and index.

Verification
REQ-032 x4, defaults: one full up cycle 00->01->11->10->00, each level held 10 cycles -> four 1-cycle cnt_enable pulses, cnt_up_down=1, each pulse 7 cycles after its edge.
REQ-033 Glitch: enc_a high for 3 cycles then low -> no cnt_enable, no phase_err.
REQ-034 x1 reverse rotation over two full cycles -> exactly two pulses, cnt_up_down=0; x2 -> four pulses.
REQ-035 A and B toggled in the same cycle 300 times -> phase_err=1, err_cnt=255, no steps; then err_clr -> both 0.
REQ-036 Index rise with idx_load_en=1, idx_val=8'hA5, coinciding with an up step -> single cycle cnt_enable=1, cnt_load_en=1, cnt_load_val=8'hA5, step dropped.
REQ-037 Reset pulsed mid-filter, inputs at 11 on release -> ready rises after 7 cycles, no step or phase_err.
